// File: rtl/aes_round_engine_pkg.sv
// aes_pkg: shared definitions for the iterative AES round engine.
//   - key_len encodings and the rounds-per-key-length lookup
//   - FSM state enum shared by the engine and anything watching its debug port
//   - S-box table function and GF(2^8) multiply helpers used by aes_lane
// No ports; imported with "import aes_pkg::*".
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    // Rounds indexed by key_len; the reserved code runs as AES-128.
    localparam logic [3:0] NR_TABLE [4] = '{4'd10, 4'd12, 4'd14, 4'd10};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Index 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        return NR_TABLE[key_len];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[x];
    endfunction

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/aes_round_engine_lane.sv
// aes_lane: combinational part of one AES column for one round.
// The caller has already applied ShiftRows, so col_in is the column as seen
// by SubBytes. Row 0 is in the MSB of every 32-bit column.
// Ports:
//   col_in      in  32  shifted state column
//   final_round in   1  bypass MixColumns (last round)
//   rk_col      in  32  matching round-key column
//   col_out     out 32  SubBytes -> MixColumns (or bypass) -> AddRoundKey
module aes_lane
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        final_round,
    input  logic [31:0] rk_col,
    output logic [31:0] col_out
);

    logic [7:0]  s0, s1, s2, s3;
    logic [31:0] sub_col;
    logic [31:0] mix_col;

    assign s0 = sbox(col_in[31:24]);
    assign s1 = sbox(col_in[23:16]);
    assign s2 = sbox(col_in[15:8]);
    assign s3 = sbox(col_in[7:0]);

    assign sub_col = {s0, s1, s2, s3};

    assign mix_col = {
        xtime(s0) ^ gf_mul3(s1) ^ s2 ^ s3,
        s0 ^ xtime(s1) ^ gf_mul3(s2) ^ s3,
        s0 ^ s1 ^ xtime(s2) ^ gf_mul3(s3),
        gf_mul3(s0) ^ s1 ^ s2 ^ xtime(s3)
    };

    assign col_out = (final_round ? sub_col : mix_col) ^ rk_col;

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128/192/256 encryption, LANES columns per
// cycle (LANES in {1,2,4}; a round takes 4/LANES cycles). Round keys come
// from an external store addressed by rk_idx and are used in the same cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on the FSM state (high in IDLE only) and
// out_valid only on the FSM state (high in DONE only), so neither is
// combinationally derived from in_valid or out_ready. dout is held while
// out_valid is high and out_ready is low.
//
// Optional feature: define AES_ROUND_CBC_EN for CBC chaining (IV loaded with
// in_valid & iv_load in IDLE; each ciphertext becomes the next chain value).
// Without it the engine is ECB only and iv_load is ignored.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   key_len      0/1/2 -> 10/12/14 rounds, 3 -> 10; sampled at accept
//   in_valid/in_ready, iv_load, din   input block handshake
//   rk_idx/rk    round-key request / key returned combinationally
//   out_valid/out_ready, dout         ciphertext handshake
//   dbg_state    current FSM state
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   key_len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         iv_load,
    input  logic [127:0] din,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output aes_state_e   dbg_state
);

    localparam logic [2:0] STEP = 3'(LANES);

    aes_state_e state_cur, state_nxt;

    // Column 0 is index 0, i.e. the most significant 32 bits.
    logic [0:3][31:0] state_q;
    logic [0:3][31:0] next_q;
    logic [0:3][31:0] next_merged;
    logic [0:3][31:0] sr_col;
    logic [0:3][31:0] rk_cols;

    logic [127:0] chain;
    logic [3:0]   round_q;
    logic [3:0]   nr_q;
    logic [1:0]   col_q;
    logic [2:0]   col_sum;
    logic         wrap;
    logic         final_round;
    logic         accept;
    logic         iv_accept;

    logic [31:0]  lane_out [LANES];
    logic [1:0]   lane_col [LANES];

    assign rk_cols     = rk;
    assign col_sum     = {1'b0, col_q} + STEP;
    assign wrap        = col_sum[2];
    assign final_round = (round_q == nr_q);
    assign dout        = state_q;
    assign dbg_state   = state_cur;

    // ShiftRows as wiring: output column j row r comes from column (j+r)%4.
    for (genvar j = 0; j < 4; j++) begin : g_sr
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_col[j][31-8*r -: 8] = state_q[(j+r)%4][31-8*r -: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_col[l] = col_q + 2'(l);

        aes_lane u_lane (
            .col_in      (sr_col[lane_col[l]]),
            .final_round (final_round),
            .rk_col      (rk_cols[lane_col[l]]),
            .col_out     (lane_out[l])
        );
    end

    // Columns finished earlier in this round plus the ones produced now; at
    // the wrap cycle this is the complete next state.
    always_comb begin
        next_merged = next_q;
        for (int l = 0; l < LANES; l++) begin
            next_merged[lane_col[l]] = lane_out[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_cur <= ST_IDLE;
        end else begin
            state_cur <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_cur;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        accept    = 1'b0;
        iv_accept = 1'b0;
        case (state_cur)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef AES_ROUND_CBC_EN
                    if (iv_load) begin
                        iv_accept = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_ROUND;
                    end
`else
                    accept    = 1'b1;
                    state_nxt = ST_ROUND;
`endif
                end
            end
            ST_ROUND: begin
                rk_idx = round_q;
                if (wrap && final_round) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            next_q  <= '0;
            round_q <= 4'd0;
            nr_q    <= 4'd0;
            col_q   <= 2'd0;
        end else if (accept) begin
            // rk_idx is 0 in IDLE, so rk is the whitening key here.
            state_q <= din ^ chain ^ rk;
            round_q <= 4'd1;
            col_q   <= 2'd0;
            nr_q    <= nr_of(key_len);
        end else if (state_cur == ST_ROUND) begin
            next_q <= next_merged;
            col_q  <= col_sum[1:0];
            if (wrap) begin
                state_q <= next_merged;
                if (!final_round) begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

`ifdef AES_ROUND_CBC_EN
    logic [127:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else if (iv_accept) begin
            chain_q <= din;
        end else if (state_cur == ST_DONE && out_ready) begin
            chain_q <= state_q;
        end
    end

    assign chain = chain_q;
`else
    logic unused_iv_load;
    logic unused_iv_accept;

    assign chain            = '0;
    assign unused_iv_load   = iv_load;
    assign unused_iv_accept = iv_accept;
`endif

endmodule
